// File: rtl/vec_regfile_stream.sv
`default_nettype none
// ============================================================================
// Module   : vec_regfile_stream
// Purpose  : Beat-serial vector register file. NUM_REGS registers of VLEN
//            bits. Register groups (LMUL = 1/2/4/8) move one VLEN-wide beat
//            per handshake, so the datapath width does not depend on LMUL.
//            Sits between vector decode/issue and the lanes/LSU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset           clock (posedge), asynchronous active-low reset
//   rd_req_*, rd_addr1/2, rd_lmul
//                        dual-source read group request
//   rd_valid/ready, rd_data1/2, rd_last, rd_err
//                        read beat stream (one beat per handshake)
//   wr_req_*, wr_addr, wr_lmul
//                        write group request
//   wr_beat_valid/ready, wr_data, wr_err
//                        write beat stream; wr_err flags a drained group
//   mask_wr_en, mask_wdata
//                        direct v0 write, independent of both FSMs
//   v0_mask_data         registered view of v0
// Optional build macro
//   VREG_HAZARD_EN       keeps a pending-write map and holds off reads whose
//                        source groups overlap a write still in flight
// ============================================================================
module vec_regfile_stream #(
  parameter int VLEN       = 512,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  // read group request
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  input  logic [1:0]            rd_lmul,
  // read beat stream
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [VLEN-1:0]       rd_data1,
  output logic [VLEN-1:0]       rd_data2,
  output logic                  rd_last,
  output logic                  rd_err,
  // write group request
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0]            wr_lmul,
  // write beat stream
  input  logic                  wr_beat_valid,
  output logic                  wr_beat_ready,
  input  logic [VLEN-1:0]       wr_data,
  output logic                  wr_err,
  // direct mask port
  input  logic                  mask_wr_en,
  input  logic [VLEN-1:0]       mask_wdata,
  output logic [VLEN-1:0]       v0_mask_data
);

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_STREAM = 2'd1,
    R_ERR    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BEAT  = 2'd1,
    W_DRAIN = 2'd2
  } wr_state_t;

  localparam logic [ADDR_WIDTH:0] c_ONE      = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);

  // A group of N = 1<<lmul registers is legal when its base is N-aligned and
  // the whole group fits inside the file. The sum is formed one bit wider so
  // a group running past the top cannot wrap around to look legal.
  function automatic logic f_group_legal(input logic [ADDR_WIDTH-1:0] addr,
                                         input logic [1:0]            lmul);
    logic [ADDR_WIDTH:0] w_n;
    logic [ADDR_WIDTH:0] w_end;
    w_n   = c_ONE << lmul;
    w_end = {1'b0, addr} + w_n;
    return ((({1'b0, addr}) & (w_n - c_ONE)) == '0) && (w_end <= c_NUM_REGS);
  endfunction

  // Index of the final beat of a group (N-1).
  function automatic logic [2:0] f_last_idx(input logic [1:0] lmul);
    logic [2:0] w_idx;
    case (lmul)
      2'd0:    w_idx = 3'd0;
      2'd1:    w_idx = 3'd1;
      2'd2:    w_idx = 3'd3;
      default: w_idx = 3'd7;
    endcase
    return w_idx;
  endfunction

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [VLEN-1:0]       r_regs [NUM_REGS];

  // read side
  rd_state_t             r_rd_state;
  rd_state_t             w_rd_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr1;
  logic [ADDR_WIDTH-1:0] r_rd_addr2;
  logic [2:0]            r_rd_beat;
  logic [2:0]            r_rd_last_idx;
  logic                  w_rd_req_fire;
  logic                  w_rd_legal;
  logic                  w_rd_blocked;
  logic [ADDR_WIDTH-1:0] w_rd_idx1;
  logic [ADDR_WIDTH-1:0] w_rd_idx2;

  // write side
  wr_state_t             r_wr_state;
  wr_state_t             w_wr_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [2:0]            r_wr_beat;
  logic [2:0]            r_wr_last_idx;
  logic                  w_wr_req_fire;
  logic                  w_wr_legal;
  logic                  w_wr_beat_fire;
  logic                  w_wr_commit;
  logic [ADDR_WIDTH-1:0] w_wr_idx;

  assign w_rd_legal    = f_group_legal(rd_addr1, rd_lmul) &&
                         f_group_legal(rd_addr2, rd_lmul);
  assign w_rd_req_fire = rd_req_valid && rd_req_ready;
  assign w_rd_idx1     = r_rd_addr1 + ADDR_WIDTH'(r_rd_beat);
  assign w_rd_idx2     = r_rd_addr2 + ADDR_WIDTH'(r_rd_beat);

  assign w_wr_legal     = f_group_legal(wr_addr, wr_lmul);
  assign w_wr_req_fire  = wr_req_valid && wr_req_ready;
  assign w_wr_beat_fire = wr_beat_valid && wr_beat_ready;
  assign w_wr_idx       = r_wr_addr + ADDR_WIDTH'(r_wr_beat);
  // v0 is owned by the mask port; a group beat landing on it is dropped.
  assign w_wr_commit    = w_wr_beat_fire && (r_wr_state == W_BEAT) &&
                          (w_wr_idx != '0);

  // --------------------------------------------------------------------------
  // Read-after-write hazard tracking
  // --------------------------------------------------------------------------
`ifdef VREG_HAZARD_EN
  logic [NUM_REGS-1:0] r_pending;

  function automatic logic [NUM_REGS-1:0] f_group_mask(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [1:0]            lmul);
    logic [NUM_REGS-1:0] w_ones;
    w_ones = (NUM_REGS'(1) << (4'd1 << lmul)) - NUM_REGS'(1);
    return w_ones << addr;
  endfunction

  // Illegal requests go straight to the error beat, so they are never held.
  assign w_rd_blocked = w_rd_legal &&
                        ((r_pending & (f_group_mask(rd_addr1, rd_lmul) |
                                       f_group_mask(rd_addr2, rd_lmul))) != '0);

  // Requests are only taken in W_IDLE, where no beats are accepted, so set
  // and clear never collide in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else if (w_wr_req_fire && w_wr_legal) begin
      r_pending <= r_pending | f_group_mask(wr_addr, wr_lmul);
    end else if (w_wr_beat_fire && (r_wr_state == W_BEAT)) begin
      r_pending[w_wr_idx] <= 1'b0;
    end
  end
`else
  assign w_rd_blocked = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    rd_req_ready   = 1'b0;
    rd_valid       = 1'b0;
    rd_last        = 1'b0;
    rd_err         = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        rd_req_ready = !w_rd_blocked;
        if (rd_req_valid && !w_rd_blocked) begin
          w_rd_state_nxt = w_rd_legal ? R_STREAM : R_ERR;
        end
      end
      R_STREAM: begin
        rd_valid = 1'b1;
        rd_last  = (r_rd_beat == r_rd_last_idx);
        if (rd_ready && (r_rd_beat == r_rd_last_idx)) begin
          w_rd_state_nxt = R_IDLE;
        end
      end
      R_ERR: begin
        rd_valid = 1'b1;
        rd_last  = 1'b1;
        rd_err   = 1'b1;
        if (rd_ready) begin
          w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr1    <= '0;
      r_rd_addr2    <= '0;
      r_rd_beat     <= '0;
      r_rd_last_idx <= '0;
    end else if (w_rd_req_fire) begin
      r_rd_addr1    <= rd_addr1;
      r_rd_addr2    <= rd_addr2;
      r_rd_beat     <= '0;
      r_rd_last_idx <= f_last_idx(rd_lmul);
    end else if ((r_rd_state == R_STREAM) && rd_ready) begin
      r_rd_beat <= r_rd_beat + 3'd1;
    end
  end

  // Beat data is read straight out of the array, so a beat reflects every
  // write committed on earlier edges; an error beat carries zeros.
  assign rd_data1 = (r_rd_state == R_STREAM) ? r_regs[w_rd_idx1] : '0;
  assign rd_data2 = (r_rd_state == R_STREAM) ? r_regs[w_rd_idx2] : '0;

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_state <= W_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    wr_req_ready   = 1'b0;
    wr_beat_ready  = 1'b0;
    wr_err         = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        wr_req_ready = 1'b1;
        if (wr_req_valid) begin
          w_wr_state_nxt = w_wr_legal ? W_BEAT : W_DRAIN;
        end
      end
      W_BEAT: begin
        wr_beat_ready = 1'b1;
        if (wr_beat_valid && (r_wr_beat == r_wr_last_idx)) begin
          w_wr_state_nxt = W_IDLE;
        end
      end
      W_DRAIN: begin
        // An illegal group still consumes its N beats so the producer
        // stays in step; the data is thrown away.
        wr_beat_ready = 1'b1;
        wr_err        = 1'b1;
        if (wr_beat_valid && (r_wr_beat == r_wr_last_idx)) begin
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_addr     <= '0;
      r_wr_beat     <= '0;
      r_wr_last_idx <= '0;
    end else if (w_wr_req_fire) begin
      r_wr_addr     <= wr_addr;
      r_wr_beat     <= '0;
      r_wr_last_idx <= f_last_idx(wr_lmul);
    end else if (w_wr_beat_fire) begin
      r_wr_beat <= r_wr_beat + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Register array. v0 is written only through the mask port, and group
  // commits never target index 0, so the two writes cannot collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (mask_wr_en) begin
        r_regs[0] <= mask_wdata;
      end
      if (w_wr_commit) begin
        r_regs[w_wr_idx] <= wr_data;
      end
    end
  end

  assign v0_mask_data = r_regs[0];

endmodule
`default_nettype wire

// File: tb/tb_vec_regfile_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_regfile_stream
// Purpose  : Self-checking bench for vec_regfile_stream. A plain array holds
//            the expected register contents; group legality is computed
//            with ordinary arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_regfile_stream;

  localparam int VL = 64;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [4:0]    rd_addr1 = '0;
  logic [4:0]    rd_addr2 = '0;
  logic [1:0]    rd_lmul = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [VL-1:0] rd_data1;
  logic [VL-1:0] rd_data2;
  logic          rd_last;
  logic          rd_err;
  logic          wr_req_valid = 1'b0;
  logic          wr_req_ready;
  logic [4:0]    wr_addr = '0;
  logic [1:0]    wr_lmul = '0;
  logic          wr_beat_valid = 1'b0;
  logic          wr_beat_ready;
  logic [VL-1:0] wr_data = '0;
  logic          wr_err;
  logic          mask_wr_en = 1'b0;
  logic [VL-1:0] mask_wdata = '0;
  logic [VL-1:0] v0_mask_data;

  always #5 clk = ~clk;

  vec_regfile_stream #(.VLEN(VL), .NUM_REGS(NR), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_lmul      (rd_lmul),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .rd_last      (rd_last),
    .rd_err       (rd_err),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_addr      (wr_addr),
    .wr_lmul      (wr_lmul),
    .wr_beat_valid(wr_beat_valid),
    .wr_beat_ready(wr_beat_ready),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .mask_wr_en   (mask_wr_en),
    .mask_wdata   (mask_wdata),
    .v0_mask_data (v0_mask_data)
  );

  logic [VL-1:0] model [NR];
  logic [VL-1:0] wbuf [8];
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int addr;
    int lmul;
    bit exp_err;
  } leg_vec_t;
  leg_vec_t tbl [10];

  task automatic chk(input string name, input logic [VL-1:0] act,
                     input logic [VL-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit legal(input int a, input int lmul);
    int n;
    n = 1 << lmul;
    return ((a % n) == 0) && ((a + n) <= NR);
  endfunction

  task automatic mask_write(input logic [VL-1:0] v);
    @(negedge clk);
    mask_wr_en = 1'b1;
    mask_wdata = v;
    @(negedge clk);
    mask_wr_en = 1'b0;
    model[0] = v;
    chk("v0_mask", v0_mask_data, v);
  endtask

  task automatic do_write(input int a, input int lmul);
    int n;
    bit lg;
    n  = 1 << lmul;
    lg = legal(a, lmul);
    @(negedge clk);
    chk("wr_req_ready", wr_req_ready, 1);
    wr_req_valid = 1'b1;
    wr_addr      = 5'(a);
    wr_lmul      = 2'(lmul);
    @(negedge clk);
    wr_req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      wr_beat_valid = 1'b1;
      wr_data       = wbuf[k];
      #1;
      chk("wr_beat_ready", wr_beat_ready, 1);
      chk("wr_err", wr_err, !lg);
      @(negedge clk);
      if (lg && (a + k) != 0) model[a + k] = wbuf[k];
    end
    wr_beat_valid = 1'b0;
    #1;
    chk("wr_idle_beat_ready", wr_beat_ready, 0);
    chk("wr_idle_err", wr_err, 0);
  endtask

  task automatic do_read(input int a1, input int a2, input int lmul,
                         input bit exp_err, input int stall_beat,
                         input int stall_cyc);
    int nb;
    int cnt;
    logic [VL-1:0] e1;
    logic [VL-1:0] e2;
    nb = exp_err ? 1 : (1 << lmul);
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_addr1     = 5'(a1);
    rd_addr2     = 5'(a2);
    rd_lmul      = 2'(lmul);
    #1;
    cnt = 0;
    while (!rd_req_ready && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 20) chk("rd_req_timeout", 0, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      e1 = exp_err ? '0 : model[a1 + b];
      e2 = exp_err ? '0 : model[a2 + b];
      if (b == stall_beat) begin
        rd_ready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          #1;
          chk("stall_valid", rd_valid, 1);
          chk("stall_data1", rd_data1, e1);
          chk("stall_last", rd_last, (b == nb - 1));
          @(negedge clk);
        end
      end
      rd_ready = 1'b1;
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data1", rd_data1, e1);
      chk("rd_data2", rd_data2, e2);
      chk("rd_last", rd_last, (b == nb - 1));
      chk("rd_err", rd_err, exp_err);
      @(negedge clk);
    end
    rd_ready = 1'b0;
    #1;
    chk("rd_idle_valid", rd_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3, 1, 1};
    tbl[1] = '{8, 2, 0};
    tbl[2] = '{28, 3, 1};
    tbl[3] = '{24, 3, 0};
    tbl[4] = '{31, 0, 0};
    tbl[5] = '{30, 1, 0};
    tbl[6] = '{30, 2, 1};
    tbl[7] = '{2, 1, 0};
    tbl[8] = '{6, 2, 1};
    tbl[9] = '{16, 3, 0};
    for (int i = 0; i < NR; i++) model[i] = '0;

    // reset state
    #1;
    chk("rst_rd_req_ready", rd_req_ready, 1);
    chk("rst_wr_req_ready", wr_req_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_wr_beat_ready", wr_beat_ready, 0);
    chk("rst_rd_data1", rd_data1, 0);
    chk("rst_v0", v0_mask_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // LMUL=4 write at v8 then dual read v8/v12
    for (int k = 0; k < 4; k++) wbuf[k] = VL'(10 + k);
    do_write(8, 2);
    do_read(8, 12, 2, 0, -1, 0);

    // illegal read then a legal one
    do_read(3, 3, 1, 1, -1, 0);
    do_read(8, 8, 2, 0, -1, 0);

    // mask write survives an LMUL=2 group write at v0
    mask_write(VL'(64'h5A5A));
    wbuf[0] = VL'(64'h11);
    wbuf[1] = VL'(64'h22);
    do_write(0, 1);
    chk("v0_kept", v0_mask_data, VL'(64'h5A5A));
    do_read(1, 0, 0, 0, -1, 0);

    // drained illegal write leaves v24..v31 untouched
    for (int k = 0; k < 8; k++) wbuf[k] = {$urandom(), $urandom()};
    do_write(24, 3);
    for (int k = 0; k < 8; k++) wbuf[k] = {$urandom(), $urandom()};
    do_write(28, 3);
    do_read(24, 24, 3, 0, -1, 0);

    // beats offered in W_IDLE are refused
    @(negedge clk);
    wr_beat_valid = 1'b1;
    wr_data       = '1;
    #1;
    chk("idle_beat_refused", wr_beat_ready, 0);
    @(negedge clk);
    wr_beat_valid = 1'b0;

    // LMUL=8 read with a 3-cycle stall mid-group
    for (int k = 0; k < 8; k++) wbuf[k] = {$urandom(), $urandom()};
    do_write(16, 3);
    do_read(16, 24, 3, 0, 3, 3);

    // legality table
    for (int i = 0; i < 10; i++) begin
      do_read(tbl[i].addr, tbl[i].addr, tbl[i].lmul, tbl[i].exp_err, -1, 0);
    end

`ifdef VREG_HAZARD_EN
    // read of v5 held until the in-flight write to v4..v5 commits
    @(negedge clk);
    wr_req_valid = 1'b1;
    wr_addr      = 5'd4;
    wr_lmul      = 2'd1;
    @(negedge clk);
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr1     = 5'd5;
    rd_addr2     = 5'd5;
    rd_lmul      = 2'd0;
    #1;
    chk("hz_block0", rd_req_ready, 0);
    repeat (2) @(negedge clk);
    chk("hz_block1", rd_req_ready, 0);
    wr_beat_valid = 1'b1;
    wr_data       = VL'(64'hC0DE0004);
    @(negedge clk);
    wr_data = VL'(64'hC0DE0005);
    #1;
    chk("hz_block_mid", rd_req_ready, 0);
    @(negedge clk);
    wr_beat_valid = 1'b0;
    model[4] = VL'(64'hC0DE0004);
    model[5] = VL'(64'hC0DE0005);
    #1;
    chk("hz_release", rd_req_ready, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    rd_ready     = 1'b1;
    #1;
    chk("hz_valid", rd_valid, 1);
    chk("hz_data", rd_data1, VL'(64'hC0DE0005));
    chk("hz_last", rd_last, 1);
    @(negedge clk);
    rd_ready = 1'b0;
`endif

    // randomized mix against the array model
    for (int it = 0; it < 40; it++) begin
      int op;
      int lm;
      int a;
      int a2;
      op = int'($urandom_range(0, 4));
      lm = int'($urandom_range(0, 3));
      if (op <= 1) begin
        if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, NR - 1));
        else a = int'($urandom_range(0, (NR >> lm) - 1)) << lm;
        for (int k = 0; k < 8; k++) wbuf[k] = {$urandom(), $urandom()};
        do_write(a, lm);
      end else if (op <= 3) begin
        if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, NR - 1));
        else a = int'($urandom_range(0, (NR >> lm) - 1)) << lm;
        a2 = int'($urandom_range(0, (NR >> lm) - 1)) << lm;
        do_read(a, a2, lm, !(legal(a, lm) && legal(a2, lm)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end else begin
        mask_write({$urandom(), $urandom()});
      end
    end

    // reset in the middle of a write group clears everything
    @(negedge clk);
    wr_req_valid = 1'b1;
    wr_addr      = 5'd8;
    wr_lmul      = 2'd2;
    @(negedge clk);
    wr_req_valid  = 1'b0;
    wr_beat_valid = 1'b1;
    wr_data       = VL'(64'hDEAD);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_beat_ready", wr_beat_ready, 0);
    chk("midrst_v0", v0_mask_data, 0);
    wr_beat_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    do_read(8, 16, 2, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
